// File: rtl/doraemon_pkg.sv
// Shared types and constants for the door-slot scheduler.
// Holds the slot/weight records, the FSM encoding and the per-slot score helper.
package doraemon_pkg;

  localparam int SLOTS   = 5;
  localparam int TOTAL   = 6000;
  localparam int ID_W    = 5;
  localparam int SC_W    = 8;
  localparam int WT_W    = 3;
  localparam int SCORE_W = 13;
  localparam int CNT_W   = 13;
  localparam int IDX_W   = 3;
  localparam int RES_W   = 8;

  localparam int DOOR_HI = 7;
  localparam int DOOR_LO = 5;
  localparam int RID_HI  = 4;
  localparam int RID_LO  = 0;

  typedef enum logic [2:0] {FILL, WAIT, CALC, EMIT, DONE} state_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [SC_W-1:0] size;
    logic [SC_W-1:0] iq;
    logic [SC_W-1:0] eq;
  } slot_t;

  typedef struct packed {
    logic [WT_W-1:0] sw;
    logic [WT_W-1:0] iw;
    logic [WT_W-1:0] ew;
  } wts_t;

  // Widest case is 3*7*255 = 5355, which still fits SCORE_W bits.
  function automatic logic [SCORE_W-1:0] slot_score(input slot_t s, input wts_t w);
    return SCORE_W'(w.sw) * SCORE_W'(s.size)
         + SCORE_W'(w.iw) * SCORE_W'(s.iq)
         + SCORE_W'(w.ew) * SCORE_W'(s.eq);
  endfunction

endpackage

// File: rtl/doraemon_sched_if.sv
// Arrival and result handshakes of the door-slot scheduler.
// master = arrival source plus result sink; slave = the scheduler.
interface doraemon_sched_if;
  import doraemon_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [ID_W-1:0]   doraemon_id;
  logic [SC_W-1:0]   size;
  logic [SC_W-1:0]   iq_score;
  logic [SC_W-1:0]   eq_score;
  logic [WT_W-1:0]   size_weight;
  logic [WT_W-1:0]   iq_weight;
  logic [WT_W-1:0]   eq_weight;
  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_data;
  logic              done;

  modport master (
    output in_valid, doraemon_id, size, iq_score, eq_score,
           size_weight, iq_weight, eq_weight, res_ready,
    input  in_ready, res_valid, res_data, done
  );

  modport slave (
    input  in_valid, doraemon_id, size, iq_score, eq_score,
           size_weight, iq_weight, eq_weight, res_ready,
    output in_ready, res_valid, res_data, done
  );

endinterface

// File: rtl/doraemon_argmax.sv
// Combinational weighted-score argmax over the door slots; zero latency.
// No backpressure; ties resolve to the lowest slot index (strict > only moves forward).
module doraemon_argmax
  import doraemon_pkg::*;
(
  input  slot_t [SLOTS-1:0] slots,
  input  wts_t              wts,
  output logic [IDX_W-1:0]  winner
);

  logic [SCORE_W-1:0] best;
  logic [SCORE_W-1:0] sc;

  always_comb begin
    winner = '0;
    best   = slot_score(slots[0], wts);
    sc     = '0;
    for (int i = 1; i < SLOTS; i++) begin
      sc = slot_score(slots[i], wts);
      if (sc > best) begin
        best   = sc;
        winner = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/doraemon_sched.sv
// Door-slot scheduler: fills SLOTS doors, then evicts the best-scoring door per arrival.
// Token valid one cycle after a post-fill accept; in_ready held low until res_ready takes it.
module doraemon_sched
  import doraemon_pkg::*;
#(
  parameter int TOTAL_N = TOTAL
)
(
  input  logic            clk,
  input  logic            rst,
  doraemon_sched_if.slave bus
);

  state_t              state, state_n;
  slot_t [SLOTS-1:0]   slots;
  slot_t               pend;
  wts_t                pend_wts;
  logic [CNT_W-1:0]    arr_cnt;
  logic [IDX_W-1:0]    fill_idx;
  logic [IDX_W-1:0]    winner;
  logic                in_ready_q;
  logic                res_valid_q;
  logic                done_q;
  logic [RES_W-1:0]    res_q;
  logic                accept;
  slot_t               arrival;
  wts_t                arr_wts;

  assign accept  = bus.in_valid && in_ready_q;
  assign arrival = '{id: bus.doraemon_id, size: bus.size, iq: bus.iq_score, eq: bus.eq_score};
  assign arr_wts = '{sw: bus.size_weight, iw: bus.iq_weight, ew: bus.eq_weight};

  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_q;
  assign bus.done      = done_q;

  doraemon_argmax u_argmax (
    .slots  (slots),
    .wts    (pend_wts),
    .winner (winner)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      FILL:    if (accept && fill_idx == IDX_W'(SLOTS - 1)) state_n = WAIT;
      WAIT:    if (accept) state_n = CALC;
      CALC:    state_n = EMIT;
      EMIT:    if (bus.res_ready) state_n = (arr_cnt == CNT_W'(TOTAL_N)) ? DONE : WAIT;
      DONE:    state_n = DONE;
      default: state_n = FILL;
    endcase
  end

  // Handshake outputs are registered from the next state so they flip on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      slots       <= '0;
      pend        <= '0;
      pend_wts    <= '0;
      arr_cnt     <= '0;
      fill_idx    <= '0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      res_q       <= '0;
    end else begin
      state       <= state_n;
      in_ready_q  <= (state_n == FILL) || (state_n == WAIT);
      res_valid_q <= (state_n == EMIT);
      done_q      <= (state_n == DONE);

      if (accept) arr_cnt <= arr_cnt + CNT_W'(1);

      if (accept && state == FILL) begin
        slots[fill_idx] <= arrival;
        fill_idx        <= fill_idx + IDX_W'(1);
      end

      if (accept && state == WAIT) begin
        pend     <= arrival;
        pend_wts <= arr_wts;
      end

      if (state == CALC) begin
        res_q[DOOR_HI:DOOR_LO] <= winner;
        res_q[RID_HI:RID_LO]   <= slots[winner].id;
        slots[winner]          <= pend;
      end
    end
  end

endmodule

// File: tb/tb_doraemon_sched.sv
// Randomized scoreboard bench for doraemon_sched built with TOTAL_N=8 (3 tokens per run).
// Stimulus pushes model-predicted tokens; an independent monitor pops and compares them.
module tb_doraemon_sched;

  localparam int NSLOT = 5;
  localparam int NARR  = 8;
  localparam int NTOK  = NARR - NSLOT;

  typedef struct {
    int id; int sz; int iq; int eq; int sw; int iw; int ew;
  } arr_t;

  logic clk;
  logic rst;
  doraemon_sched_if bus();

  doraemon_sched #(.TOTAL_N(NARR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   exp_q[$];
  int   tok_cnt  = 0;
  bit   stall    = 1'b0;
  arr_t ep[NARR];
  int   m_id[NSLOT];
  int   m_sz[NSLOT];
  int   m_iq[NSLOT];
  int   m_eq[NSLOT];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic arr_t mk(input int id, input int sz, input int iq, input int eq,
                              input int sw, input int iw, input int ew);
    arr_t a;
    a.id = id; a.sz = sz; a.iq = iq; a.eq = eq; a.sw = sw; a.iw = iw; a.ew = ew;
    return a;
  endfunction

  function automatic arr_t rnd_arr();
    return mk($urandom_range(0, 31), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NSLOT; i++) begin
      m_id[i] = 0; m_sz[i] = 0; m_iq[i] = 0; m_eq[i] = 0;
    end
  endtask

  task automatic model_fill(input int idx, input arr_t a);
    m_id[idx] = a.id; m_sz[idx] = a.sz; m_iq[idx] = a.iq; m_eq[idx] = a.eq;
  endtask

  // Reference: find the top score first, then the first door that reaches it.
  task automatic model_post(input arr_t a);
    int sc[NSLOT];
    int top;
    int w;
    top = -1;
    w   = 0;
    for (int i = 0; i < NSLOT; i++) begin
      sc[i] = a.sw * m_sz[i] + a.iw * m_iq[i] + a.ew * m_eq[i];
      if (sc[i] > top) top = sc[i];
    end
    for (int i = NSLOT - 1; i >= 0; i--)
      if (sc[i] == top) w = i;
    exp_q.push_back(w * 32 + m_id[w]);
    model_fill(w, a);
  endtask

  // Entered and left at posedge+1.
  task automatic send(input arr_t a);
    bit ok;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    bus.doraemon_id = 5'(a.id);
    bus.size        = 8'(a.sz);
    bus.iq_score    = 8'(a.iq);
    bus.eq_score    = 8'(a.eq);
    bus.size_weight = 3'(a.sw);
    bus.iq_weight   = 3'(a.iw);
    bus.eq_weight   = 3'(a.ew);
    bus.in_valid    = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("accept_within_budget", int'(ok), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_res_valid", int'(bus.res_valid), 0);
    chk("rst_res_data", int'(bus.res_data), 0);
    chk("rst_done", int'(bus.done), 0);
    exp_q.delete();
    tok_cnt = 0;
    model_clear();
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_before_first_edge", int'(bus.in_ready), 0);
    @(negedge clk);
    chk("in_ready_after_first_edge", int'(bus.in_ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic mid_reset();
    int n;
    n = 0;
    while (!bus.res_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("midrst_token_present", int'(bus.res_valid), 1);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midrst_res_valid", int'(bus.res_valid), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 0);
    chk("midrst_res_data", int'(bus.res_data), 0);
    exp_q.delete();
    tok_cnt = 0;
    model_clear();
    stall = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_episode(input bit bp, input bit midrst, input bit do_rst);
    int acc;
    if (do_rst) do_reset();
    for (int i = 0; i < NARR; i++) begin
      if ((bp || midrst) && i == NSLOT) stall = 1'b1;
      send(ep[i]);
      if (i < NSLOT) model_fill(i, ep[i]);
      else           model_post(ep[i]);
      if (bp && i == NSLOT) begin
        repeat (20) @(posedge clk);
        #1 stall = 1'b0;
      end
      if (midrst && i == NSLOT) begin
        mid_reset();
        return;
      end
    end
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    chk("done_raised", int'(bus.done), 1);
    chk("token_count", tok_cnt, NTOK);
    chk("scoreboard_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    acc = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.in_ready) acc++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("no_accept_after_done", acc, 0);
    chk("done_sticky", int'(bus.done), 1);
  endtask

  initial begin
    bus.res_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus.res_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops on every handshake seen at the falling edge ahead of the taking edge.
  initial begin
    bit stalled;
    bit post_hs;
    bit exp_done;
    int held;
    stalled = 1'b0; post_hs = 1'b0; exp_done = 1'b0; held = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0; post_hs = 1'b0;
        continue;
      end
      if (post_hs) begin
        chk("done_after_handshake", int'(bus.done), int'(exp_done));
        chk("in_ready_after_handshake", int'(bus.in_ready), int'(!exp_done));
        chk("res_valid_after_handshake", int'(bus.res_valid), 0);
        post_hs = 1'b0;
      end
      if (bus.res_valid) begin
        chk("in_ready_low_while_busy", int'(bus.in_ready), 0);
        if (stalled) chk("res_data_held", int'(bus.res_data), held);
        if (bus.res_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_token actual=%0d required=none", bus.res_data);
          end else begin
            chk("token", int'(bus.res_data), exp_q.pop_front());
          end
          tok_cnt++;
          exp_done = (tok_cnt == NTOK);
          post_hs  = 1'b1;
          stalled  = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = int'(bus.res_data);
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.doraemon_id = '0; bus.size = '0; bus.iq_score = '0; bus.eq_score = '0;
    bus.size_weight = '0; bus.iq_weight = '0; bus.eq_weight = '0;
    model_clear();

    // Fill 1..5 by size, then size-only weights evict door 4.
    for (int i = 0; i < NSLOT; i++) ep[i] = mk(i + 1, (i + 1) * 10, 0, 0, 0, 0, 0);
    ep[5] = mk(9, 0, 0, 0, 1, 0, 0);
    ep[6] = rnd_arr();
    ep[7] = rnd_arr();
    run_episode(1'b0, 1'b0, 1'b1);

    // Saturated ties: every score is 5355, door 0 must win each time.
    for (int i = 0; i < NARR; i++) ep[i] = mk(i + 1, 255, 255, 255, 7, 7, 7);
    run_episode(1'b0, 1'b0, 1'b1);

    // Same slot contents, different weights choose different doors.
    ep[0] = mk(1, 10, 0, 0, 0, 0, 0);
    ep[1] = mk(2, 200, 0, 5, 0, 0, 0);
    ep[2] = mk(3, 5, 0, 250, 0, 0, 0);
    ep[3] = mk(4, 1, 1, 1, 0, 0, 0);
    ep[4] = mk(5, 0, 0, 0, 0, 0, 0);
    ep[5] = mk(20, 0, 0, 0, 1, 0, 0);
    ep[6] = mk(21, 0, 0, 0, 0, 0, 1);
    ep[7] = rnd_arr();
    run_episode(1'b0, 1'b0, 1'b1);

    for (int i = 0; i < NARR; i++) ep[i] = rnd_arr();
    run_episode(1'b1, 1'b0, 1'b1);

    for (int i = 0; i < NARR; i++) ep[i] = rnd_arr();
    run_episode(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < NARR; i++) ep[i] = rnd_arr();
    run_episode(1'b0, 1'b0, 1'b0);

    for (int e = 0; e < 20; e++) begin
      for (int i = 0; i < NARR; i++) ep[i] = rnd_arr();
      run_episode(1'b0, 1'b0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
